and_gate_vector_checker: RTL

- Synthesizable stimulus/response engine for the team's 2-input AND gate; the hardware counterpart of the bench that drives `and_gate`.
- Drives every input combination into the DUT, waits a settle time, and compares the DUT output with the expected AND.
- Counts mismatches and reports pass/fail. Used for on-board self-test and as a reusable checker in gate-level benches.

---
 rtl/and_gate_vector_checker.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/and_gate_vector_checker.sv
// rtl/and_gate_vector_checker.sv - exhaustive stimulus/response checker for a WIDTH-bit AND gate
// Optional macro AND_CHECK_STOP_ON_ERR_EN: stop on the first mismatch and freeze the failing vector.
module and_gate_vector_checker #(
    parameter int WIDTH         = 1,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH-1:0]       dut_out_i,
    output logic [WIDTH-1:0]       a_o,
    output logic [WIDTH-1:0]       b_o,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ERR_CNT_W-1:0]   err_count,
    output logic [2*WIDTH-1:0]     vec_idx
);
    localparam int VW = 2 * WIDTH;
    localparam logic [VW-1:0]        LAST_VEC    = {VW{1'b1}};
    localparam logic [ERR_CNT_W-1:0] ERR_MAX     = {ERR_CNT_W{1'b1}};
    localparam logic [3:0]           SETTLE_LAST = 4'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             settle_cnt_q, settle_cnt_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic [ERR_CNT_W-1:0]   err_q, err_d;
    logic [VW-1:0]          vec_q, vec_d;
    logic                   mismatch;
    logic                   finish;
    logic [ERR_CNT_W-1:0]   err_inc;

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_d        = err_q;
        vec_d        = vec_q;
        mismatch     = (dut_out_i != (a_q & b_q));
        err_inc      = (err_q == ERR_MAX) ? err_q : err_q + 1'b1;
        finish       = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_DRIVE;
                    vec_d   = '0;
                    err_d   = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_DRIVE: begin
                a_d          = vec_q[VW-1:WIDTH];
                b_d          = vec_q[WIDTH-1:0];
                settle_cnt_d = '0;
                state_d      = (SETTLE_CYCLES > 0) ? S_SETTLE : S_CHECK;
            end
            S_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    err_d = err_inc;
                end
`ifdef AND_CHECK_STOP_ON_ERR_EN
                finish = mismatch || (vec_q == LAST_VEC);
`else
                finish = (vec_q == LAST_VEC);
`endif
                // vec_idx is left untouched on finish so it names the last (or failing) vector
                if (finish) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    vec_d   = vec_q + 1'b1;
                    state_d = S_DRIVE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            settle_cnt_q <= '0;
            a_q          <= '0;
            b_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            vec_q        <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            vec_q        <= vec_d;
        end
    end

    assign a_o       = a_q;
    assign b_o       = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign vec_idx   = vec_q;

endmodule
